mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles spent waiting for dmem_ack before abort.
REQ-002 SHALL have ports, one per line, as follows (clock and reset first):
  clk  input  1  single clock; all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  mem_read  input  1  load request from execute stage
  mem_write  input  1  store request from execute stage
  mem_read_sext  input  1  load is sign-extending
  iobytes  input  4  access size mask: 0001 byte, 0011 half, 1111 word
  aluout  input  32  effective byte address
  wdata  input  32  store data, right-justified
  dmem_req  output  1  memory request, held until ack
  dmem_we  output  1  request is a write
  dmem_addr  output  32  word-aligned address ({aluout[31:2],2'b00})
  dmem_be  output  4  byte enables
  dmem_wdata  output  32  lane-aligned store data
  dmem_ack  input  1  memory completion, one-cycle pulse
  dmem_rdata  input  32  read word, valid with dmem_ack
  memout  output  32  captured raw read word for the writeback formatter
  aluout_q  output  2  captured aluout[1:0]
  iobytes_q  output  4  captured iobytes
  mem_read_q  output  1  captured mem_read
  mem_read_sext_q  output  1  captured mem_read_sext
  valid  output  1  one-cycle pulse: access complete, outputs _q/memout valid
  fault  output  1  one-cycle pulse: misaligned, illegal, or timed-out access
  stall  output  1  freeze upstream pipeline
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-005 IDLE: start = mem_read|mem_write; on start, SHALL latch aluout, iobytes, wdata, mem_read, mem_read_sext; go WAIT if legal, else RESP with fault pending.
REQ-006 Illegal SHALL mean: half with aluout[0]=1; word with aluout[1:0]!=0; mem_read and mem_write both 1; iobytes not in {0001,0011,1111}.
REQ-007 WAIT: dmem_req=1 and dmem_addr/dmem_be/dmem_we/dmem_wdata SHALL be stable every cycle until dmem_ack.
REQ-008 dmem_be SHALL equal latched iobytes << aluout[1:0]; dmem_wdata SHALL equal wdata << {aluout[1:0],3'b000}.
REQ-009 On dmem_ack in WAIT, SHALL capture dmem_rdata into memout (reads only; writes leave memout unchanged) and go RESP.
REQ-010 WAIT SHALL count cycles; at TIMEOUT cycles without ack, SHALL drop dmem_req, go RESP with fault pending, memout unchanged.
REQ-011 RESP: exactly one cycle; valid=1 if no fault pending, otherwise fault=1; always returns to IDLE; start ignored in RESP.
REQ-012 stall SHALL be 1 when (IDLE and start) or WAIT, and 0 in RESP.
REQ-013 Minimum load/store latency SHALL be 3 cycles (IDLE accept, WAIT with same-cycle ack, RESP).
REQ-014 dmem_ack outside WAIT SHALL be ignored.
REQ-015 _q outputs SHALL hold their value until next accept in IDLE.

Reset
REQ-016 On reset SHALL go IDLE, clear timeout counter, and drive all outputs (including memout and _q) to 0; reset during WAIT aborts with no valid/fault.

Structure
REQ-017 FSM state encodings and iobytes codes (BYTE/HALF/WORD) SHALL live in the shared defines include used by the writeback formatter.
REQ-018 Lane alignment (REQ-008) SHALL be a combinational sub-module store_align.

Verification
REQ-019 Store byte: aluout=0x103, wdata=0xAB, iobytes=0001, ack after 2 cycles -> dmem_addr=0x100, be=1000, dmem_wdata=0xAB000000, valid once, stall 3 cycles.
REQ-020 Load half sext: aluout=0x202, ack same cycle, rdata=0x8001_1234 -> memout=0x80011234, aluout_q=2, mem_read_sext_q=1, valid at cycle 3.
REQ-021 Misaligned word: aluout=0x6, iobytes=1111 -> no dmem_req, fault pulse cycle 2, valid=0.
REQ-022 No ack, TIMEOUT=16 -> dmem_req high 16 cycles, then fault pulse, memout unchanged.
REQ-023 Reset asserted mid-WAIT -> next cycle dmem_req=0, stall=0, state IDLE, no valid/fault; late ack ignored.
REQ-024 Back-to-back load then store with start held through RESP -> second access starts only after RESP, each yields one valid.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit and the writeback formatter:
// FSM state encodings, access-size codes and the access legality check.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mau_state_e;

    localparam logic [3:0] IOB_BYTE = 4'b0001;
    localparam logic [3:0] IOB_HALF = 4'b0011;
    localparam logic [3:0] IOB_WORD = 4'b1111;

    // An access is illegal when it is both a load and a store, has an
    // unknown size code, or is not naturally aligned for its size.
    function automatic logic access_illegal(
        input logic       rd,
        input logic       wr,
        input logic [3:0] iob,
        input logic [1:0] lsb
    );
        logic size_bad_s;
        case (iob)
            IOB_BYTE: size_bad_s = 1'b0;
            IOB_HALF: size_bad_s = lsb[0];
            IOB_WORD: size_bad_s = (lsb != 2'b00);
            default:  size_bad_s = 1'b1;
        endcase
        return (rd & wr) | size_bad_s;
    endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Moves right-justified store data and the size mask onto the byte lanes
// selected by the low address bits.
module store_align (
    input  logic [3:0]  iobytes,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane
);

    // Shift enables by byte offset and data by the same number of bytes.
    always_comb begin
        be         = iobytes << byte_off;
        wdata_lane = wdata << {byte_off, 3'b000};
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a request/ack data memory.
// Accepts one access in IDLE, issues it in WAIT until ack or timeout, and
// reports completion or fault for exactly one cycle in RESP.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_read_sext,
    input  logic [3:0]  iobytes,
    input  logic [31:0] aluout,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] memout,
    output logic [1:0]  aluout_q,
    output logic [3:0]  iobytes_q,
    output logic        mem_read_q,
    output logic        mem_read_sext_q,
    output logic        valid,
    output logic        fault,
    output logic        stall
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    mau_state_e    state_r, state_nxt_s;
    logic          fault_pend_r, fault_pend_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          start_s, illegal_s, accept_s, capture_s;
    logic [3:0]    be_lane_s;
    logic [31:0]   wdata_lane_s;

    logic          dmem_req_r, dmem_we_r, valid_r, fault_r;
    logic [31:0]   dmem_addr_r, dmem_wdata_r, memout_r;
    logic [3:0]    dmem_be_r, iobytes_q_r;
    logic [1:0]    aluout_q_r;
    logic          mem_read_q_r, mem_read_sext_q_r;

    assign start_s   = mem_read | mem_write;
    assign illegal_s = access_illegal(mem_read, mem_write, iobytes, aluout[1:0]);

    store_align u_store_align (
        .iobytes    (iobytes),
        .byte_off   (aluout[1:0]),
        .wdata      (wdata),
        .be         (be_lane_s),
        .wdata_lane (wdata_lane_s)
    );

    // Next-state, timeout counting and capture decisions.
    always_comb begin
        state_nxt_s      = state_r;
        fault_pend_nxt_s = fault_pend_r;
        cnt_nxt_s        = cnt_r;
        accept_s         = 1'b0;
        capture_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    accept_s  = 1'b1;
                    cnt_nxt_s = '0;
                    if (illegal_s) begin
                        state_nxt_s      = RESP;
                        fault_pend_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s      = WAIT;
                        fault_pend_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    capture_s        = mem_read_q_r;
                    state_nxt_s      = RESP;
                    fault_pend_nxt_s = 1'b0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s      = RESP;
                    fault_pend_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s      = IDLE;
                fault_pend_nxt_s = 1'b0;
                cnt_nxt_s        = '0;
            end
        endcase
    end

    // Upstream must freeze while an access is being accepted or is in flight.
    always_comb begin
        if (state_r == WAIT) begin
            stall = 1'b1;
        end else if (state_r == IDLE) begin
            stall = start_s;
        end else begin
            stall = 1'b0;
        end
    end

    // State, latched request, captured read data and registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= IDLE;
            fault_pend_r      <= 1'b0;
            cnt_r             <= '0;
            dmem_req_r        <= 1'b0;
            dmem_we_r         <= 1'b0;
            dmem_addr_r       <= 32'h0000_0000;
            dmem_be_r         <= 4'b0000;
            dmem_wdata_r      <= 32'h0000_0000;
            memout_r          <= 32'h0000_0000;
            aluout_q_r        <= 2'b00;
            iobytes_q_r       <= 4'b0000;
            mem_read_q_r      <= 1'b0;
            mem_read_sext_q_r <= 1'b0;
            valid_r           <= 1'b0;
            fault_r           <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            fault_pend_r <= fault_pend_nxt_s;
            cnt_r        <= cnt_nxt_s;
            dmem_req_r   <= (state_nxt_s == WAIT);
            valid_r      <= (state_nxt_s == RESP) & ~fault_pend_nxt_s;
            fault_r      <= (state_nxt_s == RESP) & fault_pend_nxt_s;
            if (accept_s) begin
                dmem_we_r         <= mem_write;
                dmem_addr_r       <= {aluout[31:2], 2'b00};
                dmem_be_r         <= be_lane_s;
                dmem_wdata_r      <= wdata_lane_s;
                aluout_q_r        <= aluout[1:0];
                iobytes_q_r       <= iobytes;
                mem_read_q_r      <= mem_read;
                mem_read_sext_q_r <= mem_read_sext;
            end
            if (capture_s) begin
                memout_r <= dmem_rdata;
            end
        end
    end

    assign dmem_req        = dmem_req_r;
    assign dmem_we         = dmem_we_r;
    assign dmem_addr       = dmem_addr_r;
    assign dmem_be         = dmem_be_r;
    assign dmem_wdata      = dmem_wdata_r;
    assign memout          = memout_r;
    assign aluout_q        = aluout_q_r;
    assign iobytes_q       = iobytes_q_r;
    assign mem_read_q      = mem_read_q_r;
    assign mem_read_sext_q = mem_read_sext_q_r;
    assign valid           = valid_r;
    assign fault           = fault_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected responses are queued when an
// access is driven and compared when the unit reports valid or fault.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_read_sext = 1'b0;
    logic [3:0]  iobytes = 4'b0000;
    logic [31:0] aluout = 32'h0, wdata = 32'h0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic [31:0] memout;
    logic [1:0]  aluout_q;
    logic [3:0]  iobytes_q;
    logic        mem_read_q, mem_read_sext_q, valid, fault, stall;

    typedef struct {
        bit          exp_fault;
        logic [31:0] memout;
        logic [7:0]  qbits;   // {aluout_q, iobytes_q, mem_read_q, mem_read_sext_q}
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_memout = 32'h0;
    int          checks = 0;
    int          passes = 0;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_sext(mem_read_sext), .iobytes(iobytes), .aluout(aluout),
        .wdata(wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .memout(memout),
        .aluout_q(aluout_q), .iobytes_q(iobytes_q), .mem_read_q(mem_read_q),
        .mem_read_sext_q(mem_read_sext_q), .valid(valid), .fault(fault),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one access starting in the current cycle (cycle 1 = IDLE accept)
    // and returns at the falling edge of the response cycle. ack_at names the
    // cycle in which dmem_ack is high (-1 = never). Records observations only.
    task automatic do_access(
        input  bit rd, input bit wr, input bit sext, input logic [3:0] iob,
        input  logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
        input  int ack_at,
        output int stall_cnt, output int req_cnt, output int resp_cycle,
        output bit got_valid, output bit got_fault, output bit unstable,
        output logic [31:0] r_addr, output logic [31:0] r_wdata,
        output logic [3:0] r_be, output logic r_we
    );
        bit seen = 1'b0;
        stall_cnt = 0; req_cnt = 0; resp_cycle = -1;
        got_valid = 1'b0; got_fault = 1'b0; unstable = 1'b0;
        r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'b0000; r_we = 1'b0;
        mem_read = rd; mem_write = wr; mem_read_sext = sext; iobytes = iob;
        aluout = addr; wdata = wd; dmem_rdata = rword; dmem_ack = (ack_at == 1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                if (!seen) begin
                    seen = 1'b1;
                    r_addr = dmem_addr; r_wdata = dmem_wdata; r_be = dmem_be; r_we = dmem_we;
                end else if ({r_addr, r_wdata, r_be, r_we} != {dmem_addr, dmem_wdata, dmem_be, dmem_we}) begin
                    unstable = 1'b1;
                end
            end
            if (valid || fault) begin
                resp_cycle = cyc; got_valid = valid; got_fault = fault;
                break;
            end
            step();
            mem_read = 1'b0; mem_write = 1'b0;
            dmem_ack = (cyc + 1 == ack_at);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, valid, fault, stall} !== 5'b0) $display("FAIL reset_ctrl got %b exp 00000", {dmem_req, dmem_we, valid, fault, stall});
        else passes++;
        checks++;
        if ({memout, dmem_addr, dmem_wdata} !== 96'h0) $display("FAIL reset_data got %h %h %h exp 0", memout, dmem_addr, dmem_wdata);
        else passes++;
        checks++;
        if ({aluout_q, iobytes_q, mem_read_q, mem_read_sext_q, dmem_be} !== 12'h0) $display("FAIL reset_q got %h exp 0", {aluout_q, iobytes_q, mem_read_q, mem_read_sext_q, dmem_be});
        else passes++;
        step();
    endtask

    task automatic test_store_byte();
        int sc, rc, cy; bit gv, gf, un; logic [31:0] ra, rw; logic [3:0] rb; logic rwe;
        exp_t e;
        sb.push_back('{exp_fault: 1'b0, memout: model_memout, qbits: {2'd3, 4'b0001, 1'b0, 1'b0}});
        do_access(1'b0, 1'b1, 1'b0, 4'b0001, 32'h103, 32'hAB, 32'hDEAD_BEEF, 3,
                  sc, rc, cy, gv, gf, un, ra, rw, rb, rwe);
        checks++;
        if ({ra, rb, rw, rwe} !== {32'h100, 4'b1000, 32'hAB00_0000, 1'b1}) $display("FAIL sb_bus got %h %b %h %b exp 100 1000 ab000000 1", ra, rb, rw, rwe);
        else passes++;
        checks++;
        if (sc !== 3 || rc !== 2 || cy !== 4 || un) $display("FAIL sb_timing got stall=%0d req=%0d resp=%0d unst=%0d exp 3 2 4 0", sc, rc, cy, un);
        else passes++;
        e = sb.pop_front();
        checks++;
        if ({gv, gf} !== {~e.exp_fault, e.exp_fault} || memout !== e.memout) $display("FAIL sb_resp got v=%0d f=%0d mem=%h exp f=%0d mem=%h", gv, gf, memout, e.exp_fault, e.memout);
        else passes++;
        checks++;
        if ({aluout_q, iobytes_q, mem_read_q, mem_read_sext_q} !== e.qbits) $display("FAIL sb_q got %h exp %h", {aluout_q, iobytes_q, mem_read_q, mem_read_sext_q}, e.qbits);
        else passes++;
        step();
        @(negedge clk);
        checks++;
        if ({valid, fault, stall} !== 3'b000) $display("FAIL sb_once got %b exp 000", {valid, fault, stall});
        else passes++;
        step();
    endtask

    task automatic test_load_half_sext();
        int sc, rc, cy; bit gv, gf, un; logic [31:0] ra, rw; logic [3:0] rb; logic rwe;
        exp_t e;
        model_memout = 32'h8001_1234;
        sb.push_back('{exp_fault: 1'b0, memout: model_memout, qbits: {2'd2, 4'b0011, 1'b1, 1'b1}});
        do_access(1'b1, 1'b0, 1'b1, 4'b0011, 32'h202, 32'h0, 32'h8001_1234, 2,
                  sc, rc, cy, gv, gf, un, ra, rw, rb, rwe);
        checks++;
        if ({ra, rb, rwe} !== {32'h200, 4'b1100, 1'b0} || cy !== 3 || rc !== 1) $display("FAIL lh_bus got %h %b %b resp=%0d req=%0d exp 200 1100 0 3 1", ra, rb, rwe, cy, rc);
        else passes++;
        e = sb.pop_front();
        checks++;
        if ({gv, gf} !== {~e.exp_fault, e.exp_fault} || memout !== e.memout) $display("FAIL lh_resp got v=%0d f=%0d mem=%h exp mem=%h", gv, gf, memout, e.memout);
        else passes++;
        checks++;
        if ({aluout_q, iobytes_q, mem_read_q, mem_read_sext_q} !== e.qbits) $display("FAIL lh_q got %h exp %h", {aluout_q, iobytes_q, mem_read_q, mem_read_sext_q}, e.qbits);
        else passes++;
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] tbl_addr[5] = '{32'h6, 32'h11, 32'h20, 32'h30, 32'h40};
        logic [3:0]  tbl_iob[5]  = '{4'b1111, 4'b0011, 4'b0001, 4'b0101, 4'b0000};
        bit          tbl_rd[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bit          tbl_wr[5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            int sc, rc, cy; bit gv, gf, un; logic [31:0] ra, rw; logic [3:0] rb; logic rwe;
            exp_t e;
            sb.push_back('{exp_fault: 1'b1, memout: model_memout,
                           qbits: {tbl_addr[i][1:0], tbl_iob[i], tbl_rd[i], 1'b0}});
            do_access(tbl_rd[i], tbl_wr[i], 1'b0, tbl_iob[i], tbl_addr[i], 32'h5555_5555,
                      32'h1111_1111, 2, sc, rc, cy, gv, gf, un, ra, rw, rb, rwe);
            e = sb.pop_front();
            checks++;
            if ({gv, gf} !== {~e.exp_fault, e.exp_fault} || cy !== 2 || rc !== 0 || memout !== e.memout) $display("FAIL illegal_%0d got v=%0d f=%0d resp=%0d req=%0d mem=%h exp f=1 resp=2 req=0 mem=%h", i, gv, gf, cy, rc, memout, e.memout);
            else passes++;
            checks++;
            if ({aluout_q, iobytes_q, mem_read_q, mem_read_sext_q} !== e.qbits) $display("FAIL illegal_q_%0d got %h exp %h", i, {aluout_q, iobytes_q, mem_read_q, mem_read_sext_q}, e.qbits);
            else passes++;
            step();
        end
    endtask

    task automatic test_timeout();
        int sc, rc, cy; bit gv, gf, un; logic [31:0] ra, rw; logic [3:0] rb; logic rwe;
        exp_t e;
        sb.push_back('{exp_fault: 1'b1, memout: model_memout, qbits: {2'd0, 4'b1111, 1'b1, 1'b0}});
        do_access(1'b1, 1'b0, 1'b0, 4'b1111, 32'h400, 32'h0, 32'hFFFF_FFFF, -1,
                  sc, rc, cy, gv, gf, un, ra, rw, rb, rwe);
        e = sb.pop_front();
        checks++;
        if (rc !== 16 || cy !== 18 || sc !== 17 || un) $display("FAIL timeout_len got req=%0d resp=%0d stall=%0d exp 16 18 17", rc, cy, sc);
        else passes++;
        checks++;
        if ({gv, gf} !== {~e.exp_fault, e.exp_fault} || memout !== e.memout || dmem_req !== 1'b0) $display("FAIL timeout_resp got v=%0d f=%0d mem=%h req=%0d exp f=1 mem=%h req=0", gv, gf, memout, dmem_req, e.memout);
        else passes++;
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        model_memout = 32'hCAFE_0042;
        sb.push_back('{exp_fault: 1'b0, memout: model_memout, qbits: {2'd0, 4'b1111, 1'b1, 1'b0}});
        mem_read = 1'b1; mem_write = 1'b0; mem_read_sext = 1'b0; iobytes = 4'b1111;
        aluout = 32'h500; dmem_rdata = 32'hCAFE_0042;
        step();
        // WAIT: store presented (start held) while the load completes.
        mem_read = 1'b0; mem_write = 1'b1; iobytes = 4'b0011; aluout = 32'h602;
        wdata = 32'h0000_BEEF; dmem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h500}) $display("FAIL b2b_wait got %b %b %h exp 1 0 500", dmem_req, dmem_we, dmem_addr);
        else passes++;
        step();
        dmem_ack = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({valid, fault, stall, dmem_req} !== 4'b1000 || memout !== e.memout || {aluout_q, iobytes_q, mem_read_q, mem_read_sext_q} !== e.qbits) $display("FAIL b2b_load got v/f/s/r=%b mem=%h exp 1000 mem=%h", {valid, fault, stall, dmem_req}, memout, e.memout);
        else passes++;
        sb.push_back('{exp_fault: 1'b0, memout: model_memout, qbits: {2'd2, 4'b0011, 1'b0, 1'b0}});
        step();
        @(negedge clk);
        checks++;
        if ({valid, stall, dmem_req} !== 3'b010) $display("FAIL b2b_accept got %b exp 010", {valid, stall, dmem_req});
        else passes++;
        step();
        mem_write = 1'b0; dmem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h600, 4'b1100, 32'hBEEF_0000}) $display("FAIL b2b_store got %b %b %h %b %h exp 1 1 600 1100 beef0000", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        else passes++;
        step();
        dmem_ack = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({valid, fault} !== 2'b10 || memout !== e.memout || {aluout_q, iobytes_q, mem_read_q, mem_read_sext_q} !== e.qbits) $display("FAIL b2b_store_resp got v=%0d f=%0d mem=%h exp v=1 mem=%h", valid, fault, memout, e.memout);
        else passes++;
        step();
    endtask

    task automatic test_reset_mid_wait();
        bit extra = 1'b0;
        mem_read = 1'b1; iobytes = 4'b1111; aluout = 32'h700; dmem_rdata = 32'h7777_7777;
        step();
        mem_read = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) $display("FAIL rst_wait_pre got req=%0d exp 1", dmem_req);
        else passes++;
        step();
        reset = 1'b0; dmem_ack = 1'b1;
        model_memout = 32'h0;
        @(negedge clk);
        checks++;
        if ({dmem_req, stall, valid, fault} !== 4'b0000 || memout !== model_memout || {aluout_q, iobytes_q, mem_read_q} !== 7'h0) $display("FAIL rst_wait_post got %b mem=%h q=%h exp 0000 mem=0 q=0", {dmem_req, stall, valid, fault}, memout, {aluout_q, iobytes_q, mem_read_q});
        else passes++;
        step();
        dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid || fault || dmem_req) extra = 1'b1;
            step();
        end
        checks++;
        if (extra || memout !== model_memout) $display("FAIL rst_late_ack got extra=%0d mem=%h exp 0 mem=%h", extra, memout, model_memout);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half_sext();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
